// File: rtl/pram_loader.sv
// Boot loader: copies PROG_LEN bytes from the SPI flash reader into program RAM,
// holding the CPU in reset until the image is in place or a flash timeout aborts it.
module pram_loader #(
  parameter int PROG_LEN    = 64,
  parameter int TIMEOUT_CYC = 1048575
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       flash_strt,
  output logic [5:0] flash_char_addr,
  input  logic [7:0] flash_data,
  input  logic       flash_done,
  output logic       pram_wre,
  output logic [8:0] pram_addr,
  output logic [7:0] pram_data,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  localparam logic [5:0]  LAST = 6'(PROG_LEN - 1);
  localparam logic [19:0] TMAX = 20'(TIMEOUT_CYC - 1);

  logic [2:0]  state, state_nxt;
  logic [5:0]  idx;
  logic [19:0] timer;
  logic        start_q;
  logic        start_edge;

  assign start_edge = start & ~start_q;

  // flash_done beats the timeout when both land on the same WAIT cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (flash_done) state_nxt = WRITE;
               else if (timer == TMAX) state_nxt = ERR;
      WRITE:   state_nxt = (idx == LAST) ? DONE : REQ;
      DONE:    state_nxt = DONE;
      ERR:     if (start_edge) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Status/strobe outputs are flops fed from the next-state decode, so they
  // line up with the state they describe without combinational glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      timer           <= '0;
      start_q         <= 1'b0;
      flash_strt      <= 1'b0;
      flash_char_addr <= '0;
      pram_wre        <= 1'b0;
      pram_addr       <= '0;
      pram_data       <= '0;
      cpu_hold        <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_q    <= start;
      flash_strt <= (state_nxt == REQ);
      pram_wre   <= (state_nxt == WRITE);
      busy       <= (state_nxt == REQ) || (state_nxt == WAIT) || (state_nxt == WRITE);
      done       <= (state_nxt == DONE);
      error      <= (state_nxt == ERR);
      cpu_hold   <= (state_nxt != DONE);

      if ((state == IDLE || state == ERR) && state_nxt == REQ) begin
        idx             <= '0;
        flash_char_addr <= '0;
      end else if (state == WRITE && state_nxt == REQ) begin
        idx             <= idx + 6'd1;
        flash_char_addr <= idx + 6'd1;
      end

      if (state == REQ)
        timer <= '0;
      else if (state == WAIT && timer != TMAX)
        timer <= timer + 20'd1;

      if (state == WAIT && flash_done) begin
        pram_addr <= {3'b000, idx};
        pram_data <= flash_data;
      end
    end
  end

endmodule

// File: tb/tb_pram_loader.sv
// Bench for pram_loader: a 4-byte and a 1-byte instance driven by latency-programmable
// flash responders; writes are scoreboarded against timing/data derived from the load rules.
module tb_pram_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0;
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut4: PROG_LEN=4, TIMEOUT_CYC=16
  logic       strt4, wre4, hold4, busy4, done4, err4, fd4, fd_m4 = 1'b0, spur4 = 1'b0;
  logic [5:0] caddr4;
  logic [8:0] paddr4;
  logic [7:0] pdata4, fdata4 = '0;
  // dut1: PROG_LEN=1, TIMEOUT_CYC=16
  logic       strt1, wre1, hold1, busy1, done1, err1, fd1;
  logic [5:0] caddr1;
  logic [8:0] paddr1;
  logic [7:0] pdata1, fdata1 = '0;

  assign fd4 = fd_m4 | spur4;

  pram_loader #(.PROG_LEN(4), .TIMEOUT_CYC(16)) dut4 (
    .clk(clk), .rst(rst), .start(start), .flash_strt(strt4), .flash_char_addr(caddr4),
    .flash_data(fdata4), .flash_done(fd4), .pram_wre(wre4), .pram_addr(paddr4),
    .pram_data(pdata4), .cpu_hold(hold4), .busy(busy4), .done(done4), .error(err4));

  pram_loader #(.PROG_LEN(1), .TIMEOUT_CYC(16)) dut1 (
    .clk(clk), .rst(rst), .start(start), .flash_strt(strt1), .flash_char_addr(caddr1),
    .flash_data(fdata1), .flash_done(fd1), .pram_wre(wre1), .pram_addr(paddr1),
    .pram_data(pdata1), .cpu_hold(hold1), .busy(busy1), .done(done1), .error(err1));

  // Flash models: answer in the lat-th cycle after the request (lat=0: never), data=base+addr.
  int lat4 = 3, w4 = 0, lat1 = 2, w1 = 0;
  bit arm4 = 0, arm1 = 0;
  logic [7:0] base4 = 8'hA0, base1 = 8'h5C;
  logic [5:0] a4 = '0, a1 = '0;

  always @(negedge clk) begin
    fd_m4 = 1'b0;
    if (rst) arm4 = 0;
    else if (strt4) begin arm4 = 1; w4 = 0; a4 = caddr4; end
    else if (arm4) begin
      w4++;
      if (lat4 != 0 && w4 == lat4) begin fd_m4 = 1'b1; fdata4 = base4 + 8'(a4); arm4 = 0; end
    end
  end

  logic fd_m1 = 1'b0;
  assign fd1 = fd_m1;
  always @(negedge clk) begin
    fd_m1 = 1'b0;
    if (rst) arm1 = 0;
    else if (strt1) begin arm1 = 1; w1 = 0; a1 = caddr1; end
    else if (arm1) begin
      w1++;
      if (lat1 != 0 && w1 == lat1) begin fd_m1 = 1'b1; fdata1 = base1 + 8'(a1); arm1 = 0; end
    end
  end

  // Monitors
  logic [8:0] wa4[$], wa1[$];
  logic [7:0] wd4[$], wd1[$];
  logic [5:0] sa4[$];
  int         wc4[$], sc4[$], wc1[$];

  always @(negedge clk) begin
    if (wre4) begin wa4.push_back(paddr4); wd4.push_back(pdata4); wc4.push_back(cyc); end
    if (strt4) begin sa4.push_back(caddr4); sc4.push_back(cyc); end
    if (wre1) begin wa1.push_back(paddr1); wd1.push_back(pdata1); wc1.push_back(cyc); end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_mon();
    wa4.delete(); wd4.delete(); wc4.delete(); sa4.delete(); sc4.delete();
    wa1.delete(); wd1.delete(); wc1.delete();
  endtask

  task automatic do_reset(input bit hold_start);
    rst = 1'b1; start = hold_start; spur4 = 1'b0;
    step(); step();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic pulse_start();
    start = 1'b1; step();
    start = 1'b0; step();
  endtask

  task automatic wait_done4(input int bound, output bit ok, output int dcyc);
    ok = 0; dcyc = -1;
    for (int i = 0; i < bound; i++) begin
      if (done4) begin ok = 1; dcyc = cyc; break; end
      step();
    end
  endtask

  // Compare dut4's write log against the expected image and per-byte timing for latency lat.
  task automatic check_load(input string tag, input int lat, input logic [7:0] base, input bit ok, input int dcyc);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL %s_done_timeout: done never rose", tag); return; end
    n_chk++;
    if (wa4.size() != 4) begin n_fail++; $display("FAIL %s_wr_cnt: got %0d want 4", tag, wa4.size()); return; end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (wa4[i] !== 9'(i) || wd4[i] !== 8'(base + 8'(i))) begin
        n_fail++; $display("FAIL %s_wr%0d: got addr %0h data %0h want addr %0h data %0h",
                           tag, i, wa4[i], wd4[i], i, 8'(base + 8'(i)));
      end
      if (i > 0) begin
        n_chk++;
        if (wc4[i] - wc4[i-1] != lat + 2) begin
          n_fail++; $display("FAIL %s_spacing%0d: got %0d want %0d", tag, i, wc4[i] - wc4[i-1], lat + 2);
        end
      end
    end
    // inclusive count from the first flash_strt cycle to the first done cycle
    n_chk++;
    if (dcyc - sc4[0] + 1 != 4 * (lat + 2) + 1) begin
      n_fail++; $display("FAIL %s_done_lat: got %0d want %0d", tag, dcyc - sc4[0] + 1, 4 * (lat + 2) + 1);
    end
    n_chk++;
    if (hold4 !== 1'b0 || busy4 !== 1'b0 || err4 !== 1'b0 || sc4.size() != 4) begin
      n_fail++; $display("FAIL %s_final: got hold %b busy %b err %b strts %0d want 0 0 0 4",
                         tag, hold4, busy4, err4, sc4.size());
    end
  endtask

  task automatic check_reset_vals(input string tag);
    n_chk++;
    if ({strt4, caddr4, wre4, paddr4, pdata4, busy4, done4, err4, hold4} !== {1'b0, 6'd0, 1'b0, 9'd0, 8'd0, 4'b0001}) begin
      n_fail++; $display("FAIL %s: got strt %b caddr %0h wre %b paddr %0h pdata %0h busy %b done %b err %b hold %b",
                         tag, strt4, caddr4, wre4, paddr4, pdata4, busy4, done4, err4, hold4);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    step(); step();
    check_reset_vals("reset_dut4");
    n_chk++;
    if ({strt1, wre1, busy1, done1, err1, hold1} !== 6'b000001) begin
      n_fail++; $display("FAIL reset_dut1: got %b want 000001", {strt1, wre1, busy1, done1, err1, hold1});
    end
    rst = 1'b0; clear_mon();
  endtask

  task automatic test_normal();
    bit ok; int dc;
    do_reset(0);
    lat4 = 3; base4 = 8'hA0;
    pulse_start();
    wait_done4(200, ok, dc);
    check_load("normal", 3, 8'hA0, ok, dc);
  endtask

  task automatic test_timeout();
    bit ok; int dc, ec;
    do_reset(0);
    lat4 = 0;
    pulse_start();
    ok = 0; ec = -1;
    for (int i = 0; i < 100; i++) begin
      if (err4) begin ok = 1; ec = cyc; break; end
      step();
    end
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL tmo_err: error never rose"); end
    else begin
      n_chk++;
      if (ec - sc4[0] != 17) begin n_fail++; $display("FAIL tmo_wait_len: got %0d want 17", ec - sc4[0]); end
      n_chk++;
      if (wa4.size() != 0 || hold4 !== 1'b1 || busy4 !== 1'b0) begin
        n_fail++; $display("FAIL tmo_state: got writes %0d hold %b busy %b want 0 1 0", wa4.size(), hold4, busy4);
      end
    end
    clear_mon();
    lat4 = 2; base4 = 8'($urandom);
    pulse_start();
    n_chk++;
    if (err4 !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear: got %b want 0", err4); end
    wait_done4(200, ok, dc);
    check_load("retry", 2, base4, ok, dc);
  endtask

  task automatic test_reset_mid();
    bit ok; int dc;
    do_reset(0);
    lat4 = 3; base4 = 8'h30;
    pulse_start();
    for (int i = 0; i < 100 && wa4.size() < 2; i++) step();
    step();
    rst = 1'b1; step(); rst = 1'b0;
    check_reset_vals("rstmid_vals");
    n_chk++;
    if (wa4.size() != 2) begin n_fail++; $display("FAIL rstmid_writes: got %0d want 2", wa4.size()); end
    clear_mon();
    pulse_start();
    for (int i = 0; i < 20 && sc4.size() == 0; i++) step();
    n_chk++;
    if (sc4.size() == 0 || sa4[0] !== 6'd0) begin
      n_fail++; $display("FAIL rstmid_restart_addr: got %0h want 0", sc4.size() ? sa4[0] : 6'h3f);
    end
    wait_done4(200, ok, dc);
    check_load("rstmid_reload", 3, 8'h30, ok, dc);
  endtask

  task automatic test_start_held();
    bit ok, left; int dc;
    do_reset(1);
    start = 1'b1;
    lat4 = 4; base4 = 8'($urandom);
    for (int i = 0; i < 100 && sc4.size() < 2; i++) step();
    step(); start = 1'b0; step(); start = 1'b1;
    wait_done4(200, ok, dc);
    check_load("held", 4, base4, ok, dc);
    left = 0;
    for (int i = 0; i < 12; i++) begin
      start = i[0];
      step();
      if (done4 !== 1'b1 || hold4 !== 1'b0) left = 1;
    end
    start = 1'b0;
    n_chk++;
    if (left || sc4.size() != 4 || wa4.size() != 4) begin
      n_fail++; $display("FAIL held_done_sticky: got left %b strts %0d writes %0d want 0 4 4", left, sc4.size(), wa4.size());
    end
  endtask

  task automatic test_spurious();
    bit ok; int dc;
    do_reset(0);
    lat4 = 16; base4 = 8'($urandom);
    for (int i = 0; i < 6; i++) begin spur4 = i[0]; step(); end
    spur4 = 1'b0;
    n_chk++;
    if (busy4 !== 1'b0 || hold4 !== 1'b1 || sc4.size() != 0 || wa4.size() != 0) begin
      n_fail++; $display("FAIL spur_idle: got busy %b hold %b strts %0d writes %0d want 0 1 0 0",
                         busy4, hold4, sc4.size(), wa4.size());
    end
    start = 1'b1; step(); start = 1'b0;
    spur4 = strt4; step(); spur4 = 1'b0;
    wait_done4(400, ok, dc);
    check_load("spur_boundary", 16, base4, ok, dc);
  endtask

  task automatic test_random();
    bit ok; int dc, l;
    for (int r = 0; r < 4; r++) begin
      do_reset(0);
      l = $urandom_range(1, 16);
      lat4 = l; base4 = 8'($urandom);
      pulse_start();
      wait_done4(400, ok, dc);
      check_load($sformatf("rand%0d_lat%0d", r, l), l, base4, ok, dc);
    end
  endtask

  task automatic test_single();
    int dc;
    do_reset(0);
    lat1 = $urandom_range(1, 6); base1 = 8'h5C;
    pulse_start();
    dc = -1;
    for (int i = 0; i < 100; i++) begin
      if (done1) begin dc = cyc; break; end
      step();
    end
    n_chk++;
    if (dc < 0 || wa1.size() != 1) begin
      n_fail++; $display("FAIL single_wr_cnt: got writes %0d done_cyc %0d want 1 write", wa1.size(), dc);
    end else begin
      n_chk++;
      if (wa1[0] !== 9'd0 || wd1[0] !== 8'h5C) begin
        n_fail++; $display("FAIL single_wr: got addr %0h data %0h want 0 5c", wa1[0], wd1[0]);
      end
      n_chk++;
      if (dc != wc1[0] + 1 || hold1 !== 1'b0) begin
        n_fail++; $display("FAIL single_done: got done_cyc %0d hold %b want %0d 0", dc, hold1, wc1[0] + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_reset_mid();
    test_start_held();
    test_spurious();
    test_random();
    test_single();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pram_loader.md
# pram_loader

Boot-time controller that sequences the SPI flash reader and program RAM, copying a program image byte-by-byte from flash into PRAM before releasing the CPU. It sits between `flashNav` (drives its `strt`/`char_addr`, consumes `char_output`) and `pram` (drives its `wre`/`addr`/`data_in`). It holds the program counter and decoder in reset until the image is fully loaded, and it reports completion or a flash timeout.

## Interface

Parameters:

- `PROG_LEN`, 64: number of bytes to load. Legal range is 1..64, limited by the 6-bit flash character address.
- `TIMEOUT_CYC`, 1048575: maximum number of WAIT cycles per byte before the load is aborted. Legal range is 2..2^20-1.

Ports:

- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous and active-high.
- `start` in 1: load request. Internally rising-edge detected (button level).
- `flash_strt` out 1: one-cycle read request to the flash reader.
- `flash_char_addr` out 6: flash byte index being requested.
- `flash_data` in 8: byte returned by the flash reader. Valid when `flash_done`=1.
- `flash_done` in 1: one-cycle tick marking `flash_data` valid.
- `pram_wre` out 1: PRAM write enable.
- `pram_addr` out 9: PRAM write address, equal to {3'b0, index}.
- `pram_data` out 8: PRAM write data.
- `cpu_hold` out 1: holds PC and decoder in reset while 1.
- `busy` out 1: load in progress.
- `done` out 1: image loaded. Sticky until `rst`.
- `error` out 1: flash timeout occurred. Sticky until the next start edge or `rst`.

## Operation

- State machine: IDLE, REQ, WAIT, WRITE, DONE, ERR.
- Edge detect: `start_q` <= `start` every cycle; `start_q` resets to 0. `start_edge` = `start` & ~`start_q`. A `start` held high through reset release therefore produces exactly one edge.
- IDLE: on `start_edge`, set idx=0 and go to REQ.
- REQ: `flash_strt`=1 and `flash_char_addr`=idx. Clear the timer and go to WAIT.
- WAIT:
  - If `flash_done`=1, capture `flash_data` into a byte register and go to WRITE.
  - Otherwise the timer increments. When the timer reaches `TIMEOUT_CYC`-1 with no `flash_done`, go to ERR.
  - If `flash_done` arrives on the same cycle the timer expires, `flash_done` wins.
- WRITE: `pram_wre`=1, `pram_addr`={3'b0, idx}, `pram_data`=captured byte.
  - If idx == `PROG_LEN`-1, go to DONE.
  - Otherwise idx <= idx+1 and go to REQ.
- DONE: `done`=1 and `cpu_hold`=0. Terminal state; `start` is ignored. Only `rst` leaves DONE.
- ERR: `error`=1 and `cpu_hold`=1. On `start_edge`, clear `error`, set idx=0 and go to REQ (retry from byte 0).
- Ignored inputs:
  - `flash_done` is ignored in every state except WAIT.
  - `start_edge` is ignored in REQ, WAIT, WRITE and DONE.
- Output behaviour:
  - `flash_strt` and `pram_wre` are each high for exactly one cycle per byte.
  - `busy`=1 in REQ, WAIT and WRITE.
  - `flash_char_addr`, `pram_addr` and `pram_data` hold their last values outside REQ/WRITE.
- Width rules:
  - idx is 6 bits and never wraps, because `PROG_LEN` ≤ 64.
  - The timer is 20 bits and saturates at its compare value.

## Timing

- Reset values: state=IDLE, idx=0, timer=0, `start_q`=0, `cpu_hold`=1. All other outputs are 0: `flash_strt`, `flash_char_addr`, `pram_wre`, `pram_addr`, `pram_data`, `busy`, `done`, `error`.
- Reset mid-load: `rst` is sampled on the next `clk` and returns the block to the reset values that same edge. A partially written PRAM is not cleared. The next `start_edge` reloads from byte 0.
- All outputs are registered, i.e. decoded from registered state and data. The clock edge that samples `start_edge` in IDLE is followed by `flash_strt`=1 in the next cycle.
- Per-byte latency: 1 (REQ) + N (WAIT, where `flash_done` arrives in the Nth WAIT cycle, N≥1) + 1 (WRITE).
- The PRAM write occurs exactly 1 cycle after the cycle in which `flash_done` is sampled.
- `done` rises and `cpu_hold` falls on the same edge, 1 cycle after the final WRITE cycle.
- A timeout takes exactly `TIMEOUT_CYC` WAIT cycles. `error` rises and `busy` falls on the next edge.

## Test plan

- Normal load: `PROG_LEN`=4; flash model asserts `flash_done` in the 3rd WAIT cycle with data 0xA0+idx.
  - Required: 4 `pram_wre` pulses, addr 0..3, data 0xA0..0xA3, 5 cycles apart.
  - Required: `done`=1 and `cpu_hold`=0 exactly 21 cycles after the first `flash_strt`.
- Timeout: `TIMEOUT_CYC`=16, flash model never responds.
  - Required: `error`=1 after 16 WAIT cycles, no `pram_wre`, `cpu_hold` stays 1.
  - Then a new `start` edge with a responsive flash model must complete the load from idx 0.
- Reset mid-load: `rst` asserted for 1 cycle after the 2nd WRITE.
  - Required: all outputs return to their reset values on the next edge, with `cpu_hold`=1.
  - A subsequent `start` edge must produce `flash_char_addr`=0 first.
- Start handling: `start` held high through reset and for the whole load, plus extra `start` pulses during WAIT and in DONE.
  - Required: exactly one load of `PROG_LEN` bytes; DONE is never left.
- Spurious and boundary `flash_done`:
  - `flash_done` pulses in IDLE and REQ must cause no write and no state change.
  - With `TIMEOUT_CYC`=16, a `flash_done` in the 16th WAIT cycle must cause a WRITE, not ERR.
- Single-byte image: `PROG_LEN`=1 with data 0x5C.
  - Required: exactly one write, addr 0 data 0x5C, followed directly by DONE.
